// File: rtl/hpq_pkg.sv
// Shared types and elaboration-time helpers for the hierarchical PQ search sequencer.
// Derived geometry (rows per node, level count, per-level Yt base) is computed here from the top parameters.
package hpq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_SELECT,
    ST_FIN
  } state_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int hpq_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int hpq_vd(input int alpha, input int betta, input int ph);
    return (alpha * betta) / ph;
  endfunction

  function automatic int hpq_levels(input int n, input int alpha);
    return hpq_log2(n) / hpq_log2(alpha);
  endfunction

  // Yt region base of level l: every shallower level holds alpha^i nodes of vd rows each.
  function automatic int hpq_lbase(input int l, input int vd, input int alpha);
    int acc;
    int p;
    acc = 0;
    p   = 1;
    for (int i = 0; i < l; i++) begin
      acc = acc + p;
      p   = p * alpha;
    end
    return vd * acc;
  endfunction

endpackage

// File: rtl/hpq_addr_gen.sv
// Row counter and Yt address generator: yt_addr = LBASE[level] + node*VD + row.
// Strobe and address are registered together; all state holds while ena is low.
module hpq_addr_gen
  import hpq_pkg::*;
#(
  parameter int ALPHA = 32,
  parameter int VD    = 4,
  parameter int H     = 2,
  parameter int LW    = 2,
  parameter int NW    = 10,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          issue,
  input  logic [LW-1:0] level,
  input  logic [NW-1:0] node,
  output logic          row_last,
  output logic          yt_rd,
  output logic [AW-1:0] yt_addr
);

  localparam int RW = (VD > 1) ? hpq_log2(VD) : 1;

  logic [RW-1:0] row_q, row_d;
  logic          yt_rd_q, yt_rd_d;
  logic [AW-1:0] yt_addr_q, yt_addr_d;
  logic [AW-1:0] lbase_tab [2**LW];

  // Table padded to the full level index range so any level value selects a defined entry.
  for (genvar g = 0; g < 2**LW; g++) begin : g_lbase
    if (g < H) begin : g_used
      assign lbase_tab[g] = AW'(hpq_lbase(g, VD, ALPHA));
    end else begin : g_pad
      assign lbase_tab[g] = '0;
    end
  end

  assign row_last = (row_q == RW'(VD - 1));

  always_comb begin
    row_d     = row_q;
    yt_rd_d   = 1'b0;
    yt_addr_d = yt_addr_q;
    if (issue) begin
      yt_rd_d   = 1'b1;
      yt_addr_d = lbase_tab[level] + AW'(node) * AW'(VD) + AW'(row_q);
      row_d     = row_last ? '0 : row_q + RW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q     <= '0;
      yt_rd_q   <= 1'b0;
      yt_addr_q <= '0;
    end else if (ena) begin
      row_q     <= row_d;
      yt_rd_q   <= yt_rd_d;
      yt_addr_q <= yt_addr_d;
    end
  end

  assign yt_rd   = yt_rd_q;
  assign yt_addr = yt_addr_q;

endmodule

// File: rtl/hpq_search_sched.sv
// Phase-2 search sequencer: per level, burst VD Yt rows, wait for the min-tree winner, descend.
// Handshaked on min_vld with a TMO-cycle watchdog; ena low freezes every register and output.
module hpq_search_sched
  import hpq_pkg::*;
#(
  parameter int N     = 1024,
  parameter int ALPHA = 32,
  parameter int BETTA = 1,
  parameter int PH    = 8,
  parameter int TMO   = 64,
  parameter int AW    = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     ena,
  input  logic                                     start,
  output logic                                     busy,
  output logic                                     yt_rd,
  output logic [AW-1:0]                            yt_addr,
  input  logic                                     min_vld,
  input  logic [hpq_log2(ALPHA)-1:0]               min_idx,
  output logic [hpq_log2(hpq_levels(N, ALPHA)):0]  level,
  output logic [hpq_log2(N)-1:0]                   result_idx,
  output logic                                     done,
  output logic                                     err
);

  localparam int VD = hpq_vd(ALPHA, BETTA, PH);
  localparam int H  = hpq_levels(N, ALPHA);
  localparam int NW = hpq_log2(N);
  localparam int LW = hpq_log2(H) + 1;
  localparam int TW = hpq_log2(TMO) + 1;

  state_t        state_q, state_d;
  logic [NW-1:0] node_q, node_d;
  logic [LW-1:0] level_q, level_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [NW-1:0] result_q, result_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          row_last;

  hpq_addr_gen #(
    .ALPHA (ALPHA),
    .VD    (VD),
    .H     (H),
    .LW    (LW),
    .NW    (NW),
    .AW    (AW)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .issue    (state_q == ST_ISSUE),
    .level    (level_q),
    .node     (node_q),
    .row_last (row_last),
    .yt_rd    (yt_rd),
    .yt_addr  (yt_addr)
  );

  always_comb begin
    state_d  = state_q;
    node_d   = node_q;
    level_d  = level_q;
    tmo_d    = tmo_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          node_d  = '0;
          level_d = '0;
          busy_d  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (row_last) begin
          tmo_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (min_vld) begin
          // Child index is appended below the parent: node*ALPHA + min_idx.
          node_d  = NW'({node_q, min_idx});
          state_d = ST_SELECT;
        end else if (tmo_q == TW'(TMO - 1)) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_SELECT: begin
        if (level_q == LW'(H - 1)) begin
          result_d = node_q;
          done_d   = 1'b1;
          state_d  = ST_FIN;
        end else begin
          level_d = level_q + LW'(1);
          state_d = ST_ISSUE;
        end
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      node_q   <= '0;
      level_q  <= '0;
      tmo_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      node_q   <= node_d;
      level_q  <= level_d;
      tmo_q    <= tmo_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy       = busy_q;
  assign level      = level_q;
  assign result_idx = result_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
